// File: rtl/struct_record_packer.sv
// Byte-stream to packed {tag, a, b} record assembler with a mid-record stall timeout.
// Define STRUCT_RECORD_PACKER_PARITY_EN to add a trailing even-parity byte checked into out_err.
module struct_record_packer #(
   parameter int unsigned IDLE_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_tag,
   output logic [31:0] out_a,
   output logic [7:0]  out_b,
   output logic        out_err,
   output logic [7:0]  drop_cnt
);

`ifdef STRUCT_RECORD_PACKER_PARITY_EN
   localparam int unsigned NumBytes = 7;
`else
   localparam int unsigned NumBytes = 6;
`endif
   localparam int unsigned TmoW    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [2:0]  LastIdx = 3'(NumBytes - 1);

   typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

   state_e          r_state, w_state_next;
   logic [2:0]      r_idx;
   logic [TmoW-1:0] r_tmo;
   logic [7:0]      r_tag, r_b, r_drop;
   logic [31:0]     r_a;
   logic            w_accept, w_timeout;

   assign w_accept  = in_valid && in_ready;
   // Acceptance in the same cycle always beats the timeout.
   assign w_timeout = (IDLE_TIMEOUT != 0) && (r_state == StCollect) && !w_accept &&
                      (r_tmo == TmoW'(IDLE_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_next = StCollect;
         end
         StCollect: begin
            if (w_accept && (r_idx == LastIdx)) w_state_next = StHold;
            else if (w_timeout)                 w_state_next = StIdle;
         end
         StHold: begin
            if (out_ready) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (r_state != StHold);
      out_valid = (r_state == StHold);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_tmo  <= '0;
         r_drop <= '0;
      end else begin
         if (w_state_next == StIdle) r_idx <= '0;
         else if (w_accept)          r_idx <= r_idx + 3'd1;

         if ((IDLE_TIMEOUT != 0) && (r_state == StCollect) && !w_accept && !w_timeout)
            r_tmo <= r_tmo + TmoW'(1);
         else
            r_tmo <= '0;

         if (w_timeout && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag <= '0;
         r_a   <= '0;
         r_b   <= '0;
      end else if (w_accept) begin
         case (r_idx)
            3'd0:    r_tag       <= in_data;
            3'd1:    r_a[31:24]  <= in_data;
            3'd2:    r_a[23:16]  <= in_data;
            3'd3:    r_a[15:8]   <= in_data;
            3'd4:    r_a[7:0]    <= in_data;
            3'd5:    r_b         <= in_data;
            default: ;
         endcase
      end
   end

`ifdef STRUCT_RECORD_PACKER_PARITY_EN
   logic [7:0] r_par;
   logic [7:0] w_par_calc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         r_par <= '0;
      else if (w_accept && r_idx == 3'd6) r_par <= in_data;
   end

   assign w_par_calc = r_tag ^ r_a[31:24] ^ r_a[23:16] ^ r_a[15:8] ^ r_a[7:0] ^ r_b;
   assign out_err    = out_valid && (r_par != w_par_calc);
`else
   assign out_err = 1'b0;
`endif

   assign out_tag  = r_tag;
   assign out_a    = r_a;
   assign out_b    = r_b;
   assign drop_cnt = r_drop;

endmodule
